iod_tx_training_gen: RTL and testbench
======================================

# iod_tx_training_gen

Fabric-side transmit word generator for one 8:1 TX I/O lane, the transmit-end counterpart of the clock-training receive lane. It drives the parallel TX data of a TX IOD with a fixed training pattern until the far-end receiver reports lock, then emits a short sync preamble, then forwards payload words under a valid/ready handshake. It sits between the payload source and the TX IOD wrapper, clocked by the same fabric clock as the IOD TX_CLK.

## Interface
- TRAIN_PATTERN, 8'hF0: word sent during TRAIN; an edge-rich pattern for the far-end eye monitor.
- TRAIN_WORDS, 256: minimum number of TRAIN words; range 2..65535.
- SYNC_WORD, 8'hBC: preamble word sent in SYNC.
- SYNC_WORDS, 4: number of SYNC words; range 1..255.
- IDLE_WORD, 8'h00: word sent in IDLE, and in DATA when no payload is accepted.
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- ARST_N  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to FAB_CLK (released by an upstream synchroniser).
- TRAIN_REQ  in  1  single-cycle request to (re)start training.
- PEER_LOCK  in  1  far-end receiver locked; already synchronous to FAB_CLK.
- PAYLOAD_DATA  in  8  payload word.
- PAYLOAD_VALID  in  1  payload word available.
- PAYLOAD_READY  out  1  block accepts a word this cycle.
- TX_DATA_0  out  8  parallel word to the TX IOD.
- TX_OE_0  out  1  output enable to the TX IOD.
- LINK_UP  out  1  high only in DATA.
- TRAINING  out  1  high only in TRAIN.

## Operation
- States: IDLE, TRAIN, SYNC, DATA.
- IDLE: TX_DATA_0=IDLE_WORD, TX_OE_0=0. TRAIN_REQ -> TRAIN.
- TRAIN: TX_DATA_0=TRAIN_PATTERN, TX_OE_0=1. Word counter starts at 0 and saturates at TRAIN_WORDS-1. Transition to SYNC when the counter reaches TRAIN_WORDS-1 and PEER_LOCK=1. Otherwise the block stays in TRAIN indefinitely (no timeout).
- SYNC: TX_DATA_0=SYNC_WORD for exactly SYNC_WORDS cycles, then DATA. If PEER_LOCK drops during SYNC, go to TRAIN with the counter cleared.
- DATA: PAYLOAD_READY = (state==DATA) & PEER_LOCK & ~TRAIN_REQ, decoded combinationally from the state register and inputs. A word is accepted when VALID&READY, and TX_DATA_0 carries it on the next cycle. With no handshake, TX_DATA_0=IDLE_WORD. PEER_LOCK=0 in DATA -> TRAIN (retrain) with the counter cleared.
- TRAIN_REQ in any non-IDLE state returns the block to TRAIN with the counter cleared. TRAIN_REQ takes priority over every other transition.
- Simultaneous events:
  - TRAIN_REQ together with VALID in DATA: the word is not accepted; READY is 0.
  - PEER_LOCK fall on the cycle the counter reaches its terminal value: stay in TRAIN.
- Counter width: $clog2(TRAIN_WORDS). The SYNC counter is 8 bits.

## Timing
- Reset values: state=IDLE, TX_DATA_0=IDLE_WORD, TX_OE_0=0, LINK_UP=0, TRAINING=0, PAYLOAD_READY=0, both counters 0.
- All outputs except PAYLOAD_READY are registered.
- TX_DATA_0, TX_OE_0, LINK_UP and TRAINING update on the same edge as the state register, so the first TRAIN word appears on the edge after TRAIN_REQ is sampled.
- Exactly TRAIN_WORDS pattern words is the minimum (PEER_LOCK held high throughout).
- Payload latency: 1 cycle from handshake to TX_DATA_0. Throughput is 1 word per cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any in-flight payload word is discarded.

## Structure
- Package iod_tx_train_pkg holds:
  - the state enum (IDLE, TRAIN, SYNC, DATA);
  - the default pattern, sync and idle word constants.
- One sub-module, iod_tx_train_cnt: a parameterised saturating up-counter with synchronous clear and terminal flag. It is instantiated twice, for TRAIN and for SYNC.
- The top module contains the FSM, output registers and the handshake.

## Test plan
- Reset, then TRAIN_REQ with PEER_LOCK=1 -> exactly 256 × 8'hF0, 4 × 8'hBC, then LINK_UP=1 and READY=1 on the next cycle.
- PEER_LOCK held at 0 for 1000 cycles after TRAIN_REQ, then raised -> 8'hF0 continues throughout; SYNC starts 1 cycle after the rise.
- In DATA, stream 8'h01..8'h10 with VALID toggling every other cycle -> each word on TX_DATA_0 one cycle after its handshake, 8'h00 in the gaps, no loss or duplication.
- PEER_LOCK dropped in DATA with VALID=1 -> READY=0 the same cycle, TRAINING=1 and 8'hF0 the next cycle, count restarts at 0.
- TRAIN_REQ during SYNC and during DATA -> back to TRAIN, a full 256 pattern words resent; a payload word offered with TRAIN_REQ is not accepted.
- ARST_N asserted mid-stream -> TX_OE_0=0 and TX_DATA_0=8'h00 without waiting for a clock edge; after release the block stays in IDLE until TRAIN_REQ.

Source files
------------

// File: rtl/iod_tx_train_pkg.sv
// Shared types and default words for the TX training generator.
// Imported by the counter and the top-level FSM.
package iod_tx_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_SYNC  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hF0;
  localparam logic [7:0] DEF_SYNC_WORD     = 8'hBC;
  localparam logic [7:0] DEF_IDLE_WORD     = 8'h00;
  localparam int         DEF_TRAIN_WORDS   = 256;
  localparam int         DEF_SYNC_WORDS    = 4;

endpackage

// File: rtl/iod_tx_train_cnt.sv
// Saturating up-counter with synchronous clear and terminal flag.
// Holds at LAST once reached until cleared.
module iod_tx_train_cnt
  import iod_tx_train_pkg::*;
#(
  parameter int W    = 8,
  parameter int LAST = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign term = (cnt == LAST_V);

endmodule

// File: rtl/iod_tx_training_gen.sv
// TX lane word generator: training pattern, sync preamble, then
// payload forwarding under a valid/ready handshake.
module iod_tx_training_gen
  import iod_tx_train_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int         TRAIN_WORDS   = DEF_TRAIN_WORDS,
  parameter logic [7:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int         SYNC_WORDS    = DEF_SYNC_WORDS,
  parameter logic [7:0] IDLE_WORD     = DEF_IDLE_WORD
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_REQ,
  input  logic       PEER_LOCK,
  input  logic [7:0] PAYLOAD_DATA,
  input  logic       PAYLOAD_VALID,
  output logic       PAYLOAD_READY,
  output logic [7:0] TX_DATA_0,
  output logic       TX_OE_0,
  output logic       LINK_UP,
  output logic       TRAINING
);

  localparam int TW_W = $clog2(TRAIN_WORDS);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] tx_d;
  logic       tr_term;
  logic       sy_term;
  logic       accept;

  assign PAYLOAD_READY = (state_q == ST_DATA) & PEER_LOCK & ~TRAIN_REQ;
  assign accept        = PAYLOAD_READY & PAYLOAD_VALID;

  // A restart request inside TRAIN must also zero the word count.
  iod_tx_train_cnt #(
    .W    (TW_W),
    .LAST (TRAIN_WORDS - 1)
  ) u_train_cnt (
    .clk   (FAB_CLK),
    .rst_n (ARST_N),
    .clr   ((state_q != ST_TRAIN) | TRAIN_REQ),
    .en    (state_q == ST_TRAIN),
    .term  (tr_term)
  );

  iod_tx_train_cnt #(
    .W    (8),
    .LAST (SYNC_WORDS - 1)
  ) u_sync_cnt (
    .clk   (FAB_CLK),
    .rst_n (ARST_N),
    .clr   (state_q != ST_SYNC),
    .en    (state_q == ST_SYNC),
    .term  (sy_term)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = IDLE_WORD;
    unique case (state_q)
      ST_IDLE:  if (TRAIN_REQ) state_d = ST_TRAIN;
      ST_TRAIN: if (tr_term && PEER_LOCK) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!PEER_LOCK)   state_d = ST_TRAIN;
        else if (sy_term) state_d = ST_DATA;
      end
      ST_DATA:  if (!PEER_LOCK) state_d = ST_TRAIN;
      default:  state_d = ST_IDLE;
    endcase
    if (TRAIN_REQ) state_d = ST_TRAIN;

    unique case (state_d)
      ST_TRAIN: tx_d = TRAIN_PATTERN;
      ST_SYNC:  tx_d = SYNC_WORD;
      ST_DATA:  tx_d = accept ? PAYLOAD_DATA : IDLE_WORD;
      default:  tx_d = IDLE_WORD;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q   <= ST_IDLE;
      TX_DATA_0 <= IDLE_WORD;
      TX_OE_0   <= 1'b0;
      LINK_UP   <= 1'b0;
      TRAINING  <= 1'b0;
    end else begin
      state_q   <= state_d;
      TX_DATA_0 <= tx_d;
      TX_OE_0   <= (state_d != ST_IDLE);
      LINK_UP   <= (state_d == ST_DATA);
      TRAINING  <= (state_d == ST_TRAIN);
    end
  end

endmodule

// File: tb/tb_iod_tx_training_gen.sv
// Scenario bench for iod_tx_training_gen with a rule-level
// reference model and randomized lock/payload stimulus.
module tb_iod_tx_training_gen;

  localparam int         TW   = 256;
  localparam int         SW   = 4;
  localparam logic [7:0] PAT  = 8'hF0;
  localparam logic [7:0] SYNW = 8'hBC;
  localparam logic [7:0] IDLW = 8'h00;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       TRAIN_REQ = 1'b0;
  logic       PEER_LOCK = 1'b0;
  logic [7:0] PAYLOAD_DATA = 8'h00;
  logic       PAYLOAD_VALID = 1'b0;
  logic       PAYLOAD_READY;
  logic [7:0] TX_DATA_0;
  logic       TX_OE_0;
  logic       LINK_UP;
  logic       TRAINING;

  int n_checks = 0;
  int n_fail   = 0;

  iod_tx_training_gen dut (
    .FAB_CLK       (FAB_CLK),
    .ARST_N        (ARST_N),
    .TRAIN_REQ     (TRAIN_REQ),
    .PEER_LOCK     (PEER_LOCK),
    .PAYLOAD_DATA  (PAYLOAD_DATA),
    .PAYLOAD_VALID (PAYLOAD_VALID),
    .PAYLOAD_READY (PAYLOAD_READY),
    .TX_DATA_0     (TX_DATA_0),
    .TX_OE_0       (TX_OE_0),
    .LINK_UP       (LINK_UP),
    .TRAINING      (TRAINING)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic count_words(input logic [7:0] w, output int n);
    n = 0;
    while (TX_DATA_0 === w && TX_OE_0 === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic train_to_data();
    int n;
    PEER_LOCK = 1'b1;
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    n = 0;
    while (LINK_UP !== 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    n_checks++;
    if (LINK_UP !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_data: got link_up=%b want 1", LINK_UP);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({TX_OE_0, LINK_UP, TRAINING, PAYLOAD_READY} !== 4'b0000 ||
        TX_DATA_0 !== IDLW) begin
      n_fail++;
      $display("FAIL reset_out: got oe=%b lu=%b tr=%b rdy=%b d=%h want 0 0 0 0 %h",
               TX_OE_0, LINK_UP, TRAINING, PAYLOAD_READY, TX_DATA_0, IDLW);
    end
    tick();
    tick();
    ARST_N = 1'b1;
    PEER_LOCK = 1'b1;
    PAYLOAD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (TX_OE_0 !== 1'b0 || TRAINING !== 1'b0 || PAYLOAD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got oe=%b tr=%b rdy=%b want 0 0 0",
               TX_OE_0, TRAINING, PAYLOAD_READY);
    end
    PAYLOAD_VALID = 1'b0;
  endtask

  // mode 0: lock always high; 1: low for 1000 cycles;
  // 2: random lock; 3: lock falls exactly at terminal count
  task automatic test_training(input int mode);
    bit lv[2048];
    int exp_n;
    int n;
    for (int i = 0; i < 2048; i++) begin
      unique case (mode)
        0: lv[i] = 1'b1;
        1: lv[i] = (i >= 1000);
        2: lv[i] = (i > TW + 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: lv[i] = !(i == TW - 1 || i == TW);
      endcase
    end
    if (mode == 2 && $urandom_range(0, 1) == 1) lv[TW - 1] = 1'b0;
    exp_n = 0;
    for (int i = TW - 1; i < 2048 && exp_n == 0; i++)
      if (lv[i]) exp_n = i + 1;
    PEER_LOCK = 1'b1;
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    n = 0;
    while (TX_DATA_0 === PAT && TRAINING === 1'b1 && n < 4000) begin
      PEER_LOCK = (n < 2048) ? lv[n] : 1'b1;
      n++;
      tick();
    end
    n_checks++;
    if (n != exp_n) begin
      n_fail++;
      $display("FAIL train_words_m%0d: got %0d want %0d", mode, n, exp_n);
    end
    PEER_LOCK = 1'b1;
    count_words(SYNW, n);
    n_checks++;
    if (n != SW) begin
      n_fail++;
      $display("FAIL sync_words_m%0d: got %0d want %0d", mode, n, SW);
    end
    n_checks++;
    if (LINK_UP !== 1'b1 || PAYLOAD_READY !== 1'b1 ||
        TX_DATA_0 !== IDLW || TRAINING !== 1'b0) begin
      n_fail++;
      $display("FAIL data_entry_m%0d: got lu=%b rdy=%b d=%h tr=%b want 1 1 %h 0",
               mode, LINK_UP, PAYLOAD_READY, TX_DATA_0, TRAINING, IDLW);
    end
  endtask

  task automatic test_stream();
    logic       v;
    logic [7:0] d;
    logic [7:0] exp_d;
    int         bad_rdy;
    int         bad_dat;
    int         n_acc;
    int         n_seen;
    logic [7:0] nxt;
    train_to_data();
    bad_rdy = 0;
    bad_dat = 0;
    n_acc = 0;
    n_seen = 0;
    nxt = 8'h01;
    for (int i = 0; i < 72; i++) begin
      if (i < 32) begin
        v = (i % 2 == 0);
        d = v ? nxt : 8'h00;
        if (v) nxt = nxt + 8'h01;
      end else begin
        v = $urandom_range(0, 1) == 1;
        d = 8'($urandom_range(1, 255));
      end
      PAYLOAD_VALID = v;
      PAYLOAD_DATA  = d;
      #1;
      if (PAYLOAD_READY !== 1'b1) bad_rdy++;
      if (v) n_acc++;
      exp_d = v ? d : IDLW;
      tick();
      if (TX_DATA_0 !== exp_d) begin
        bad_dat++;
        if (bad_dat < 4)
          $display("FAIL stream_word%0d: got %h want %h", i, TX_DATA_0, exp_d);
      end
      if (TX_DATA_0 !== IDLW) n_seen++;
    end
    PAYLOAD_VALID = 1'b0;
    n_checks++;
    if (bad_rdy != 0) begin
      n_fail++;
      $display("FAIL stream_ready: got %0d low cycles want 0", bad_rdy);
    end
    n_checks++;
    if (bad_dat != 0) n_fail++;
    n_checks++;
    if (n_seen != n_acc) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words want %0d", n_seen, n_acc);
    end
  endtask

  task automatic test_data_lock_drop();
    int n;
    train_to_data();
    PAYLOAD_VALID = 1'b1;
    PAYLOAD_DATA  = 8'h77;
    PEER_LOCK     = 1'b0;
    #1;
    n_checks++;
    if (PAYLOAD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ready: got %b want 0", PAYLOAD_READY);
    end
    tick();
    PAYLOAD_VALID = 1'b0;
    n_checks++;
    if (TRAINING !== 1'b1 || TX_DATA_0 !== PAT || LINK_UP !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_retrain: got tr=%b d=%h lu=%b want 1 %h 0",
               TRAINING, TX_DATA_0, LINK_UP, PAT);
    end
    PEER_LOCK = 1'b1;
    count_words(PAT, n);
    n_checks++;
    if (n != TW) begin
      n_fail++;
      $display("FAIL drop_count: got %0d want %0d", n, TW);
    end
  endtask

  task automatic test_sync_lock_drop();
    int n;
    int j;
    j = $urandom_range(0, SW - 1);
    PEER_LOCK = 1'b1;
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    count_words(PAT, n);
    for (int i = 0; i < j; i++) tick();
    n_checks++;
    if (TX_DATA_0 !== SYNW) begin
      n_fail++;
      $display("FAIL sdrop_in_sync: got %h want %h", TX_DATA_0, SYNW);
    end
    PEER_LOCK = 1'b0;
    tick();
    PEER_LOCK = 1'b1;
    count_words(PAT, n);
    n_checks++;
    if (n != TW) begin
      n_fail++;
      $display("FAIL sdrop_count: got %0d want %0d", n, TW);
    end
  endtask

  task automatic test_req_sync();
    int n;
    int j;
    j = $urandom_range(0, SW - 1);
    PEER_LOCK = 1'b1;
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    count_words(PAT, n);
    for (int i = 0; i < j; i++) tick();
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    n_checks++;
    if (TRAINING !== 1'b1 || TX_DATA_0 !== PAT) begin
      n_fail++;
      $display("FAIL req_sync_retrain: got tr=%b d=%h want 1 %h",
               TRAINING, TX_DATA_0, PAT);
    end
    count_words(PAT, n);
    n_checks++;
    if (n != TW) begin
      n_fail++;
      $display("FAIL req_sync_count: got %0d want %0d", n, TW);
    end
  endtask

  task automatic test_req_data();
    int n;
    train_to_data();
    TRAIN_REQ     = 1'b1;
    PAYLOAD_VALID = 1'b1;
    PAYLOAD_DATA  = 8'hAA;
    #1;
    n_checks++;
    if (PAYLOAD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL req_data_ready: got %b want 0", PAYLOAD_READY);
    end
    tick();
    TRAIN_REQ = 1'b0;
    PAYLOAD_VALID = 1'b0;
    n_checks++;
    if (TX_DATA_0 !== PAT || TRAINING !== 1'b1) begin
      n_fail++;
      $display("FAIL req_data_word: got d=%h tr=%b want %h 1",
               TX_DATA_0, TRAINING, PAT);
    end
    count_words(PAT, n);
    n_checks++;
    if (n != TW) begin
      n_fail++;
      $display("FAIL req_data_count: got %0d want %0d", n, TW);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    train_to_data();
    PAYLOAD_VALID = 1'b1;
    PAYLOAD_DATA  = 8'h5A;
    tick();
    PAYLOAD_DATA  = 8'h7E;
    n_checks++;
    if (TX_DATA_0 !== 8'h5A) begin
      n_fail++;
      $display("FAIL arst_pre: got %h want 5a", TX_DATA_0);
    end
    #2;
    ARST_N = 1'b0;
    #1;
    n_checks++;
    if (TX_OE_0 !== 1'b0 || TX_DATA_0 !== IDLW || LINK_UP !== 1'b0 ||
        PAYLOAD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_async: got oe=%b d=%h lu=%b rdy=%b want 0 %h 0 0",
               TX_OE_0, TX_DATA_0, LINK_UP, PAYLOAD_READY, IDLW);
    end
    tick();
    ARST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TX_OE_0 !== 1'b0 || TRAINING !== 1'b0 || PAYLOAD_READY !== 1'b0 ||
          TX_DATA_0 !== IDLW) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL arst_idle: got %0d active cycles want 0", bad);
    end
    PAYLOAD_VALID = 1'b0;
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    n_checks++;
    if (TRAINING !== 1'b1 || TX_DATA_0 !== PAT || TX_OE_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_restart: got tr=%b d=%h oe=%b want 1 %h 1",
               TRAINING, TX_DATA_0, TX_OE_0, PAT);
    end
  endtask

  initial begin
    test_reset();
    test_training(0);
    test_stream();
    test_data_lock_drop();
    test_training(1);
    test_training(2);
    test_training(2);
    test_training(3);
    test_sync_lock_drop();
    test_req_sync();
    test_req_data();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
